// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan controller.
package seven_seg_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int BRIGHT_W   = 4;
    localparam int IDX_W      = 2;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [NUM_DIGITS*BCD_W-1:0] digits;
        logic [NUM_DIGITS-1:0]       dp;
        logic [BRIGHT_W-1:0]         bright;
        logic                        lzs;
    } frame_t;
endpackage

// File: rtl/seven_seg_frame_buf.sv
// Double-buffered display frame: pending slot filled by the load handshake,
// copied into the active frame at each frame boundary.
module seven_seg_frame_buf
    import seven_seg_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_valid,
    input  frame_t load_frame,
    input  logic   boundary,
    output logic   load_ready,
    output frame_t active,
    output logic   frame_tick
);
    logic   pend_full;
    frame_t pend;
    logic   accept;

    assign accept     = load_valid && !pend_full;
    assign load_ready = !pend_full;

    always_ff @(posedge clk) begin
        if (accept) begin
            pend <= load_frame;
        end
    end

    // accept needs an empty slot and the copy needs a full one, so they never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full  <= 1'b0;
            frame_tick <= 1'b0;
            active     <= '{digits: '0, dp: '0, bright: '1, lzs: 1'b0};
        end else begin
            frame_tick <= boundary && pend_full;
            if (accept) begin
                pend_full <= 1'b1;
            end else if (boundary && pend_full) begin
                active    <= pend;
                pend_full <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Digit scan scheduler: blank/on slot FSM, brightness PWM, leading-zero
// suppression and registered digit select / code / decimal-point outputs.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DWELL_CYC = 100000,
    parameter int BLANK_CYC = 2000,
    parameter int PWM_DIV   = 4096
) (
    input  logic                        clk,
    input  logic                        rst_btn,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [NUM_DIGITS*BCD_W-1:0] load_digits,
    input  logic [NUM_DIGITS-1:0]       load_dp,
    input  logic [BRIGHT_W-1:0]         load_bright,
    input  logic                        load_lzs,
    output logic [NUM_DIGITS-1:0]       sel,
    output logic [BCD_W-1:0]            dig_code,
    output logic                        dp,
    output logic                        frame_tick
);
    localparam int ON_CYC = DWELL_CYC - BLANK_CYC;
    localparam int CNT_W  = $clog2(DWELL_CYC);
    localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PWM_DIV - 1);

    scan_state_t           state;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [BRIGHT_W-1:0]   phase;
    frame_t                load_frame;
    frame_t                active;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] supp;
    logic [NUM_DIGITS-1:0] sel_nxt;
    logic [BCD_W-1:0]      cur_code;

    assign load_frame = '{digits: load_digits, dp: load_dp, bright: load_bright, lzs: load_lzs};
    assign boundary   = (state == ST_BLANK) && (cnt == BLANK_LAST) && (idx == '0);
    assign cur_code   = active.digits[{idx, 2'b00} +: BCD_W];

    seven_seg_frame_buf u_frame_buf (
        .clk        (clk),
        .rst_n      (rst_btn),
        .load_valid (load_valid),
        .load_frame (load_frame),
        .boundary   (boundary),
        .load_ready (load_ready),
        .active     (active),
        .frame_tick (frame_tick)
    );

    // A digit is blanked only if it and every more significant digit are zero
    always_comb begin
        supp    = '0;
        supp[3] = active.lzs && (active.digits[15:12] == '0);
        supp[2] = supp[3] && (active.digits[11:8] == '0);
        supp[1] = supp[2] && (active.digits[7:4] == '0);
        sel_nxt = '1;
        if (state == ST_ON && phase < active.bright && !supp[idx]) begin
            sel_nxt[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state    <= ST_BLANK;
            idx      <= '0;
            cnt      <= '0;
            div_cnt  <= '0;
            phase    <= '0;
            sel      <= '1;
            dig_code <= '0;
            dp       <= 1'b0;
        end else begin
            sel      <= sel_nxt;
            dig_code <= (state == ST_ON) ? cur_code : '0;
            dp       <= (state == ST_ON) && active.dp[idx];
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state   <= ST_ON;
                        cnt     <= '0;
                        div_cnt <= '0;
                        phase   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ON: begin
                    if (cnt == ON_LAST) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                        idx   <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        phase   <= phase + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end
endmodule
